// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback stage.
//   DATA_W / ADDR_W / NREG : register-file geometry (16 x 18)
//   wb_src_t               : which source owns the register-file write slot this cycle
//   sel_hit()              : qualified register-select compare used by the hazard logic
package writeback_unit_pkg;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 4;
    localparam int NREG   = 1 << ADDR_W;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_MEM  = 2'd1,
        WB_HOLD = 2'd2,
        WB_ALU  = 2'd3
    } wb_src_t;

    function automatic logic sel_hit(input logic             v,
                                     input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b);
        return v && (a == b);
    endfunction

endpackage

// File: rtl/writeback_unit_scoreboard.sv
// wb_scoreboard: one pending bit per register, tracking loads that have been
// issued but whose data has not yet returned.
//   clk, rst            : clock, asynchronous active-high reset (clears all bits)
//   set_en / set_idx    : mark a register pending (load issued)
//   clr_en / clr_idx    : clear a register's pending bit (load returned)
//   look_*_idx/_pend    : three combinational lookups (ALU dest, load-issue dest, mem dest)
//   pending             : full pending vector, for the read-select hazard checks
module wb_scoreboard
    import writeback_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] look_a_idx,
    input  logic [ADDR_W-1:0] look_b_idx,
    input  logic [ADDR_W-1:0] look_c_idx,
    output logic              look_a_pend,
    output logic              look_b_pend,
    output logic              look_c_pend,
    output logic [NREG-1:0]   pending
);

    logic [NREG-1:0] pending_nxt;

    // The set is applied after the clear so a same-register set/clear leaves it pending.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) pending_nxt[clr_idx] = 1'b0;
        if (set_en) pending_nxt[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    assign look_a_pend = pending[look_a_idx];
    assign look_b_pend = pending[look_b_idx];
    assign look_c_pend = pending[look_c_idx];

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: sole driver of the register-file write port. Merges ALU
// results and memory load returns into one registered write, keeps a per-register
// load scoreboard, and flags read-after-write hazards for the two read selects.
//   clk, rst                          : clock, asynchronous active-high reset
//   alu_valid/alu_dest/alu_result     : ALU result offer; alu_ready accepts it
//   ld_issue/ld_issue_dest            : load issue; ld_issue_ready accepts it
//   mem_valid/mem_dest/mem_data       : load return, always accepted
//   read_sel1/2 -> hazard1/2          : snooped read selects and their hazard flags
//   reg_write_en/write_sel/write_data : registered register-file write port
//   wb_err                            : sticky, load return to a non-pending register
//
// Handshakes: a transfer on alu_* or ld_issue* happens in exactly the cycle where
// valid (alu_valid / ld_issue) and ready (alu_ready / ld_issue_ready) are both
// high at the rising edge; ready is combinational and never depends on valid.
// mem_valid has no ready and is consumed every cycle it is high.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_result,
    output logic              alu_ready,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_issue_dest,
    output logic              ld_issue_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] read_sel1,
    input  logic [ADDR_W-1:0] read_sel2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] write_sel,
    output logic [DATA_W-1:0] write_data,
    output logic              wb_err
);

    logic              pend_alu;
    logic              pend_ld;
    logic              pend_mem;
    logic [NREG-1:0]   pending;

    logic              hold_valid;
    logic [ADDR_W-1:0] hold_dest;
    logic [DATA_W-1:0] hold_data;

    logic              alu_fire;
    logic              ld_fire;
    logic              mem_ok;
    logic              hold_load;
    logic              hold_drain;

    // Current write-slot owner, kept as a named signal for observation.
    wb_src_t           wb_src;
    logic              nxt_en;
    logic [ADDR_W-1:0] nxt_sel;
    logic [DATA_W-1:0] nxt_data;

    assign mem_ok         = mem_valid & pend_mem;
    assign alu_ready      = ~hold_valid & ~pend_alu;
    assign alu_fire       = alu_valid & alu_ready;
    assign ld_issue_ready = ~pend_ld;
    assign ld_fire        = ld_issue & ld_issue_ready;

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (ld_fire),
        .set_idx     (ld_issue_dest),
        .clr_en      (mem_ok),
        .clr_idx     (mem_dest),
        .look_a_idx  (alu_dest),
        .look_b_idx  (ld_issue_dest),
        .look_c_idx  (mem_dest),
        .look_a_pend (pend_alu),
        .look_b_pend (pend_ld),
        .look_c_pend (pend_mem),
        .pending     (pending)
    );

    // Any mem_valid owns the write slot, even an erroneous one that writes nothing;
    // the hold buffer therefore only drains in a cycle with no mem_valid at all.
    always_comb begin
        wb_src = WB_NONE;
        if (mem_valid) begin
            wb_src = mem_ok ? WB_MEM : WB_NONE;
        end else if (hold_valid) begin
            wb_src = WB_HOLD;
        end else if (alu_fire) begin
            wb_src = WB_ALU;
        end
    end

    always_comb begin
        nxt_en   = 1'b0;
        nxt_sel  = '0;
        nxt_data = '0;
        case (wb_src)
            WB_MEM: begin
                nxt_en   = 1'b1;
                nxt_sel  = mem_dest;
                nxt_data = mem_data;
            end
            WB_HOLD: begin
                nxt_en   = 1'b1;
                nxt_sel  = hold_dest;
                nxt_data = hold_data;
            end
            WB_ALU: begin
                nxt_en   = 1'b1;
                nxt_sel  = alu_dest;
                nxt_data = alu_result;
            end
            default: begin
                nxt_en   = 1'b0;
                nxt_sel  = '0;
                nxt_data = '0;
            end
        endcase
    end

    // alu_fire implies the hold is empty, so load and drain are mutually exclusive.
    assign hold_load  = alu_fire & mem_valid;
    assign hold_drain = hold_valid & ~mem_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_dest  <= '0;
            hold_data  <= '0;
        end else if (hold_load) begin
            hold_valid <= 1'b1;
            hold_dest  <= alu_dest;
            hold_data  <= alu_result;
        end else if (hold_drain) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_en <= 1'b0;
            write_sel    <= '0;
            write_data   <= '0;
            wb_err       <= 1'b0;
        end else begin
            reg_write_en <= nxt_en;
            write_sel    <= nxt_sel;
            write_data   <= nxt_data;
            wb_err       <= wb_err | (mem_valid & ~pend_mem);
        end
    end

    // The register file commits reg_write_en at the following edge, so a value
    // sitting in the output register is not yet readable.
    assign hazard1 = pending[read_sel1]
                   | sel_hit(hold_valid, hold_dest, read_sel1)
                   | sel_hit(reg_write_en, write_sel, read_sel1);
    assign hazard2 = pending[read_sel2]
                   | sel_hit(hold_valid, hold_dest, read_sel2)
                   | sel_hit(reg_write_en, write_sel, read_sel2);

endmodule
